// File: rtl/alu_sched_pkg.sv
// Shared constants, FSM state type and ALU control-code helper for alu_scheduler.
package alu_sched_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) ||
           (ctrl == ALU_OR)  || (ctrl == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr, cyclically.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    grant_idx
);

  int unsigned     idx;
  logic [IdxW-1:0] idx_sel;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx     = (32'(ptr) + i) % NUM_REQ;
      idx_sel = IdxW'(idx);
      if (enable && !found && req[idx_sel]) begin
        found          = 1'b1;
        grant[idx_sel] = 1'b1;
        grant_idx      = idx_sel;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external single-cycle ALU between NUM_REQ requesters.
// Optional illegal-code check enabled by defining ALU_SCHED_ILLEGAL_CHK_EN (adds rsp_err_o).
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned ID_W       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [4*NUM_REQ-1:0]  req_ctrl_i,
  input  logic [32*NUM_REQ-1:0] req_data1_i,
  input  logic [32*NUM_REQ-1:0] req_data2_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [31:0]           rsp_data_o,
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
  output logic                  rsp_err_o,
`endif
  output logic [3:0]            alu_ctrl_o,
  output logic [31:0]           alu_data1_o,
  output logic [31:0]           alu_data2_o,
  input  logic [31:0]           alu_data_i,
  output logic                  busy_o
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_ctrl_q, op_ctrl_d;
  logic [31:0]       op_data1_q, op_data1_d;
  logic [31:0]       op_data2_q, op_data2_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
  logic              err_q, err_d;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    grant_idx;
  logic               arb_en;
  logic               accept;
  logic [3:0]         sel_ctrl;
  logic [31:0]        sel_data1;
  logic [31:0]        sel_data2;

  // Gating with rst_i keeps req_ready_o low while reset is held.
  assign arb_en = (state_q == IDLE) && rst_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (PtrW)
  ) u_rr_arbiter (
    .req       (req_valid_i),
    .ptr       (rr_ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept    = |(req_valid_i & grant);
  assign sel_ctrl  = req_ctrl_i[{grant_idx, 2'b00} +: 4];
  assign sel_data1 = req_data1_i[{grant_idx, 5'b00000} +: 32];
  assign sel_data2 = req_data2_i[{grant_idx, 5'b00000} +: 32];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    op_ctrl_d  = op_ctrl_q;
    op_data1_d = op_data1_q;
    op_data2_d = op_data2_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_ctrl_d  = sel_ctrl;
          op_data1_d = sel_data1;
          op_data2_d = sel_data2;
          id_d       = ID_W'(grant_idx);
          rr_ptr_d   = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
          cnt_d      = (sel_ctrl == ALU_MUL) ? CntW'(MUL_CYCLES - 1) : '0;
          state_d    = EXEC;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
          err_d = !is_legal_ctrl(sel_ctrl);
          if (!is_legal_ctrl(sel_ctrl)) begin
            state_d    = RESP;
            rsp_data_d = '0;
          end
`endif
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          rsp_data_d = alu_data_i;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      op_ctrl_q  <= '0;
      op_data1_q <= '0;
      op_data2_q <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      op_ctrl_q  <= op_ctrl_d;
      op_data1_q <= op_data1_d;
      op_data2_q <= op_data2_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = rsp_data_q;
  assign alu_ctrl_o  = op_ctrl_q;
  assign alu_data1_o = op_data1_q;
  assign alu_data2_o = op_data2_q;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
  assign rsp_err_o   = err_q && (state_q == RESP);
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed cases then random traffic vs. a reference model.
module tb_alu_scheduler;

  localparam int unsigned NumReq    = 2;
  localparam int unsigned MulCycles = 3;
  localparam int unsigned IdW       = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NumReq-1:0]     req_valid;
  logic [NumReq-1:0]     req_ready;
  logic [4*NumReq-1:0]   req_ctrl;
  logic [32*NumReq-1:0]  req_data1;
  logic [32*NumReq-1:0]  req_data2;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IdW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic [3:0]            alu_ctrl;
  logic [31:0]           alu_d1;
  logic [31:0]           alu_d2;
  logic [31:0]           alu_res;
  logic                  busy;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
  logic                  rsp_err;
`endif

  logic [3:0]        op_ctrl [NumReq];
  logic [31:0]       op_d1   [NumReq];
  logic [31:0]       op_d2   [NumReq];
  logic [NumReq-1:0] pending = '0;
  int                model_ptr = 0;
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  alu_scheduler #(
    .NUM_REQ    (NumReq),
    .MUL_CYCLES (MulCycles),
    .ID_W       (IdW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_ctrl_i  (req_ctrl),
    .req_data1_i (req_data1),
    .req_data2_i (req_data2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    .rsp_err_o   (rsp_err),
`endif
    .alu_ctrl_o  (alu_ctrl),
    .alu_data1_o (alu_d1),
    .alu_data2_o (alu_d2),
    .alu_data_i  (alu_res),
    .busy_o      (busy)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1010: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] pick_ctrl();
    case ($urandom_range(0, 5))
      0: return 4'b0010;
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      4: return 4'b1010;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // External ALU model fed by the scheduler's operand outputs.
  always_comb alu_res = alu_fn(alu_ctrl, alu_d1, alu_d2);

  always_comb begin
    req_ctrl  = '0;
    req_data1 = '0;
    req_data2 = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_ctrl[4*k +: 4]   = op_ctrl[k];
      req_data1[32*k +: 32] = op_d1[k];
      req_data2[32*k +: 32] = op_d2[k];
    end
  end

  assign req_valid = pending;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
    op_ctrl[k] = c;
    op_d1[k]   = a;
    op_d2[k]   = b;
    pending[k] = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, "_alu_d1"}, alu_d1, 32'd0);
    chk({tag, "_alu_d2"}, alu_d2, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
`endif
  endtask

  // One transaction from the current IDLE cycle through the response handshake.
  task automatic serve(input int stall);
    int                g;
    int                lat;
    logic [3:0]        c;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       exp_data;
    logic [NumReq-1:0] exp_rdy;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    logic              illegal;
`endif
    g = -1;
    for (int i = 0; i < NumReq; i++) begin
      int k;
      k = (model_ptr + i) % NumReq;
      if (g < 0 && pending[k]) g = k;
    end
    if (g < 0) return;
    exp_rdy    = '0;
    exp_rdy[g] = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(exp_rdy));
    chk("idle_busy", 32'(busy), 32'd0);
    c        = op_ctrl[g];
    a        = op_d1[g];
    b        = op_d2[g];
    exp_data = alu_fn(c, a, b);
    lat      = (c == 4'b1010) ? MulCycles + 1 : 2;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    illegal = !(c inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1010});
    if (illegal) lat = 1;
`endif
    step();
    pending[g] = 1'b0;
    model_ptr  = (g + 1) % NumReq;
    for (int cyc = 1; cyc < lat; cyc++) begin
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_ready", 32'(req_ready), 32'd0);
      chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(c));
      chk("exec_alu_d1", alu_d1, a);
      chk("exec_alu_d2", alu_d2, b);
      step();
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_busy", 32'(busy), 32'd1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_ready_out", 32'(req_ready), 32'd0);
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    chk("rsp_err", 32'(rsp_err), 32'(illegal));
`endif
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, exp_data);
      chk("stall_id", 32'(rsp_id), 32'(g));
      chk("stall_ready_out", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NumReq; k++) begin
      op_ctrl[k] = '0;
      op_d1[k]   = '0;
      op_d2[k]   = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Contention: grants alternate 0,1,0,1; first is the single add 5+7
    set_op(0, 4'b0010, 32'd5, 32'd7);
    set_op(1, 4'b0110, 32'd100, 32'd1);
    serve(0);
    set_op(0, 4'b0001, 32'h0f0, 32'h00f);
    serve(0);
    set_op(1, 4'b0000, 32'hff00, 32'h0ff0);
    serve(0);
    serve(0);

    // Multiply from requester 1 with 5 cycles of backpressure
    set_op(1, 4'b1010, 32'd6, 32'd7);
    serve(5);

    // Illegal code
    set_op(0, 4'b1111, 32'd3, 32'd4);
    serve(1);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NumReq; k++) begin
        if (!pending[k] && $urandom_range(0, 1) == 1)
          set_op(k, pick_ctrl(), 32'($urandom), 32'($urandom));
      end
      if (pending == '0) set_op(int'($urandom_range(0, NumReq - 1)), pick_ctrl(),
                                32'($urandom), 32'($urandom));
      serve(int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a multiply drops it
    set_op(1, 4'b1010, 32'd9, 32'd9);
    #1;
    step();
    pending[1] = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    pending[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    pending[0] = 1'b0;
    model_ptr  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("drop_valid", 32'(rsp_valid), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);
    end

    // Pointer restarted at 0 after reset
    set_op(0, 4'b0010, 32'd1, 32'd2);
    set_op(1, 4'b0010, 32'd3, 32'd4);
    serve(0);
    serve(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
Shares the single-cycle combinational ALU between NUM_REQ requesters, e.g. the EX stage and a secondary address/iteration unit. It arbitrates requests round-robin, latches the operands, and drives the ALU control code and operands. It holds multiply operations for MUL_CYCLES cycles to meet timing, then returns the tagged result over a valid/ready response channel. It sits between the requesters and the ALU instance; the ALU itself stays external.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
MUL_CYCLES, 2, cycles the EXEC state lasts for multiply (ctrl 1010); legal range >=1.
ID_W, 2, width of the requester index in rsp_id_o; must satisfy 2**ID_W >= NUM_REQ.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
req_valid_i  in  NUM_REQ  per-requester request valid.
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
req_ctrl_i  in  4*NUM_REQ  packed ALU control codes; requester k occupies bits [4k+3:4k].
req_data1_i  in  32*NUM_REQ  packed operand 1.
req_data2_i  in  32*NUM_REQ  packed operand 2.
rsp_valid_o  out  1  result valid.
rsp_ready_i  in  1  consumer accepts result.
rsp_id_o  out  ID_W  index of the requester that owns the result.
rsp_data_o  out  32  result.
alu_ctrl_o  out  4  to ALU control input.
alu_data1_o  out  32  to ALU operand 1.
alu_data2_o  out  32  to ALU operand 2.
alu_data_i  in  32  from ALU result.
busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states:
  - IDLE: on accept, go to EXEC.
  - EXEC: after its cycle count, go to RESP.
  - RESP: on rsp_ready_i, go to IDLE.
- Arbitration:
  - Active only in IDLE.
  - Grant goes to the first valid requester at or after rr_ptr, searching cyclically.
  - req_ready_o[g] = 1 for the granted index only; combinational from req_valid_i and rr_ptr.
  - req_ready_o is all zero outside IDLE.
- Accept happens when req_valid_i[g] and req_ready_o[g] are both high.
  - Latch ctrl, data1 and data2 of requester g into op registers, and latch g as the response id.
  - Set rr_ptr = (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when nothing is accepted.
- EXEC:
  - alu_ctrl_o, alu_data1_o and alu_data2_o are driven from the op registers, which stay stable in every state.
  - Length is MUL_CYCLES cycles when ctrl = 1010, otherwise 1 cycle; tracked by a down-counter loaded at accept.
  - On the last EXEC cycle, register alu_data_i into rsp_data_o.
- RESP:
  - rsp_valid_o = 1; rsp_data_o and rsp_id_o are held stable until rsp_ready_i is sampled high.
  - Then rsp_valid_o falls and the FSM returns to IDLE.
  - No new accept happens in the handshake cycle.
- Latency:
  - Non-multiply: accept at cycle T, rsp_valid_o high at T+2.
  - Multiply: rsp_valid_o high at T+1+MUL_CYCLES.
  - Peak throughput is one op per 3 cycles.
- Codes are passed to the ALU unmodified:
  - Add 0010, sub 0110, and 0000, or 0001, mul 1010.
  - Any other code yields result 0 from the ALU and is returned as 0 with no stall.
- Widths: results are 32-bit and truncated by the ALU; the scheduler performs no arithmetic itself.
- Simultaneous requests: exactly one is granted per IDLE cycle; losers keep req_valid_i high and retry.
- Requesters must not drop req_valid_i before ready.
- Reset, asserted at any time including mid-EXEC or mid-RESP:
  - Immediately: state = IDLE, rr_ptr = 0, counter = 0.
  - All outputs 0: rsp_valid_o, rsp_data_o, rsp_id_o, alu_ctrl_o, alu_data1_o, alu_data2_o, busy_o, req_ready_o.
  - Any in-flight op is dropped with no response.

Optional Feature:
- Macro: ALU_SCHED_ILLEGAL_CHK_EN.
- Defined:
  - Adds output port rsp_err_o (1 bit), which is 1 alongside the response when the latched ctrl is not one of the five legal codes.
  - Illegal ops skip EXEC: IDLE goes directly to RESP with rsp_data_o = 0, so rsp_valid_o is high at T+1.
  - rsp_err_o is 0 at reset.
- Undefined: no rsp_err_o port; illegal codes behave exactly like legal ones.

Decomposition:
- Package alu_sched_pkg holds:
  - ALU control code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL.
  - FSM state encoding: IDLE, EXEC, RESP.
  - Helper function is_legal_ctrl.
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.

Test Plan:
- Single add: req0 ctrl 0010, data1 5, data2 7, accepted at T -> at T+2 rsp_valid 1, rsp_data 12, rsp_id 0; alu_ctrl_o 0010 during EXEC.
- Contention: req0 and req1 both valid after reset -> req0 granted first with id 0; req1 next with id 1. Both still valid again -> req0 granted (rr_ptr wrapped to 0). Repeated -> grants alternate 0,1,0,1.
- Multiply, MUL_CYCLES=3: req1 ctrl 1010, data1 6, data2 7, accepted at T -> busy_o high T+1..T+4, rsp_valid at T+4, data 42, id 1.
- Backpressure: rsp_ready_i held 0 for 5 cycles during RESP -> rsp_valid/data/id stable; req_ready_o all 0 despite req_valid_i. ready 1 -> IDLE next cycle, then new accept.
- Reset mid-EXEC of a multiply -> all outputs 0 asynchronously; after release with no requests, no response ever appears.
- Illegal code 1111, data1 3, data2 4, with ALU_SCHED_ILLEGAL_CHK_EN -> rsp_valid at T+1, data 0, err 1. Without the macro -> rsp_valid at T+2, data 0.
